mm_param: RTL
=============

MM_PARAM -- requirements
Module: mm_param

Interface
REQ-001 Parameter DW, default 20: signed element width of A and B, and width of read_data.
REQ-002 Parameter AW, default 20: width of i, j and of every dimension.
REQ-003 Parameter GW, default 8: accumulator guard bits; internal accumulator is 2*DW+GW bits.
REQ-004 Port clk  input  1  clock; all state updates on rising edge.
REQ-005 Port reset  input  1  asynchronous, active-low reset.
REQ-006 Port start  input  1  begin one matrix-multiply job; sampled in IDLE only.
REQ-007 Port read_data  input  DW  combinational memory return for the current i, j and index.
REQ-008 Port i, j  output  AW  each  memory row/column address, registered.
REQ-009 Port read, write  output  1  each  memory strobes.
REQ-010 Port index  output  1  0 selects A/header, 1 selects B.
REQ-011 Port write_data  output  2*DW  C element, valid while write=1 and read=0.
REQ-012 Port busy  output  1  high in every state except IDLE.
REQ-013 Port finish  output  1  single-cycle job-complete pulse.

Function
REQ-014 States: IDLE, DIM, RDA, RDB, WR, DONE.
REQ-015 IDLE: read=0, write=0; start=1 -> DIM with i=0, j=0; otherwise hold.
REQ-016 DIM: read=1, write=1, index=0, i=0,1,2 on consecutive cycles; latch N, K, P (low AW bits of read_data, unsigned) at i=0, 1, 2.
REQ-017 After i=2: if N, K or P is 0 -> DONE, no writes; else -> RDA with row=0, col=0, k=0.
REQ-018 RDA: read=1, write=0, index=0, i=row, j=k; capture A element; -> RDB.
REQ-019 RDB: read=1, write=0, index=1, i=k, j=col; acc += signed(A)*signed(read_data), sign-extended to 2*DW+GW.
REQ-020 In RDB: if k=K-1 -> WR; else k+1 -> RDA.
REQ-021 WR: read=0, write=1, index=0, i=row, j=col, write_data = output-converted acc; acc cleared to 0 on exit.
REQ-022 In WR: if col<P-1 -> col+1; else col=0, row+1. Last element (row=N-1, col=P-1) -> DONE; else -> RDA with k=0.
REQ-023 DONE lasts one cycle with finish=1, read=0, write=0; then IDLE, busy=0.
REQ-024 Latency: start to finish = 3 + N*P*(2K+1) + 1 cycles, start cycle excluded.
REQ-025 start while busy=1 is ignored and has no effect on the current job.
REQ-026 C is written in row-major order, each element exactly once.

Reset
REQ-027 reset=0 immediately forces state=IDLE and clears i, j, read, write, index, write_data, busy, finish, acc, row, col, k and dims to 0.
REQ-028 Reset mid-job abandons the job with no further writes; a new start is required after release.

Configuration
REQ-029 Macro MM_SAT_EN defined: write_data clamps acc to [-2^(2DW-1), 2^(2DW-1)-1].
REQ-030 Macro MM_SAT_EN undefined: write_data = acc[2DW-1:0], wrapping two's-complement truncation.

Verification (DW=20, AW=20, GW=8)
REQ-031 A=[[1,2],[3,4]], B=[[5,6],[7,8]], start pulse -> writes (0,0)=19, (0,1)=22, (1,0)=43, (1,1)=50 in that order; finish exactly 24 cycles after start.
REQ-032 N=K=P=1, A=-3, B=7 -> single write of write_data=40'hFFFFFFFFEB at i=0, j=0.
REQ-033 Header N=0, K=3, P=2 -> no write=1 cycle after DIM; finish 4 cycles after start.
REQ-034 K=2, N=P=1, all elements -524288 -> MM_SAT_EN gives 40'h7FFFFFFFFF; without the macro gives 40'h8000000000.
REQ-035 reset=0 asserted during RDB of the 2x2 job -> all outputs 0 in the same cycle; after release, no memory activity until start.
REQ-036 start=1 pulsed during WR of a running job -> job result and finish timing identical to REQ-031.

Source files
------------

// File: rtl/mm_param_if.sv
// mm_param_if -- memory/control bus of the mm_param matrix-multiply engine.
//
// Signals:
//   start      : controller -> engine, begin one job (sampled in IDLE only)
//   read_data  : memory -> engine, combinational return for (i, j, index)
//   i, j       : engine -> memory, row/column address
//   read/write : engine -> memory, strobes (both high = header fetch)
//   index      : engine -> memory, 0 selects A/header, 1 selects B
//   write_data : engine -> memory, C element, valid while write=1, read=0
//   busy       : engine -> controller, high outside IDLE
//   finish     : engine -> controller, one-cycle job-complete pulse
//   dbg_state  : engine FSM state, for observation only
//
// Handshake: there is no backpressure. The engine owns the bus timing; the
// memory must return read_data combinationally in the same cycle that
// i/j/index/read are presented, and must accept a write in the cycle that
// write=1 and read=0.
//
// Modports: slave = engine side, master = controller/memory side.
interface mm_param_if #(
    parameter int DW = 20,
    parameter int AW = 20
);
    logic              start;
    logic [DW-1:0]     read_data;
    logic [AW-1:0]     i;
    logic [AW-1:0]     j;
    logic              read;
    logic              write;
    logic              index;
    logic [2*DW-1:0]   write_data;
    logic              busy;
    logic              finish;
    logic [2:0]        dbg_state;

    modport slave (
        input  start, read_data,
        output i, j, read, write, index, write_data, busy, finish, dbg_state
    );

    modport master (
        output start, read_data,
        input  i, j, read, write, index, write_data, busy, finish, dbg_state
    );
endinterface

// File: rtl/mm_param.sv
// mm_param -- sequential matrix multiply C = A x B over an external memory.
//
// A job reads a three-word header (N, K, P) at index 0, i = 0..2, then for
// each C element in row-major order alternates A/B reads K times, accumulating
// signed products in a 2*DW+GW bit accumulator, and writes the element.
//
// Ports:
//   clk    : clock, all state updates on rising edge
//   reset  : asynchronous, active-low reset
//   bus    : mm_param_if.slave (start, read_data, i, j, read, write, index,
//            write_data, busy, finish, dbg_state)
//
// Build option:
//   MM_SAT_EN : when defined, write_data saturates the accumulator to the
//               signed 2*DW range; otherwise the low 2*DW bits are written
//               (two's-complement wrap).
module mm_param #(
    parameter int DW = 20,
    parameter int AW = 20,
    parameter int GW = 8
) (
    input  logic     clk,
    input  logic     reset,
    mm_param_if.slave bus
);
    localparam int ACCW = 2 * DW + GW;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DIM  = 3'd1,
        RDA  = 3'd2,
        RDB  = 3'd3,
        WR   = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t                  state;
    logic [AW-1:0]           dim_n, dim_k, dim_p;
    logic [AW-1:0]           row, col, k;
    logic signed [DW-1:0]    a_reg;
    logic signed [ACCW-1:0]  acc;
    logic signed [ACCW-1:0]  acc_next;
    logic signed [2*DW-1:0]  prod;
    logic [AW-1:0]           rd_dim;

    assign bus.dbg_state = state;
    assign rd_dim        = bus.read_data[AW-1:0];

    always_comb begin
        prod     = a_reg * $signed(bus.read_data);
        acc_next = acc + {{GW{prod[2*DW-1]}}, prod};
    end

    // Accumulator to output-width conversion.
    function automatic logic [2*DW-1:0] to_out(input logic signed [ACCW-1:0] a);
`ifdef MM_SAT_EN
        // In range exactly when the guard bits and the output sign bit agree.
        if (a[ACCW-1:2*DW-1] == {(GW+1){1'b0}} || a[ACCW-1:2*DW-1] == {(GW+1){1'b1}})
            return a[2*DW-1:0];
        else if (a[ACCW-1])
            return {1'b1, {(2*DW-1){1'b0}}};
        else
            return {1'b0, {(2*DW-1){1'b1}}};
`else
        return a[2*DW-1:0];
`endif
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            bus.i          <= '0;
            bus.j          <= '0;
            bus.read       <= 1'b0;
            bus.write      <= 1'b0;
            bus.index      <= 1'b0;
            bus.write_data <= '0;
            bus.busy       <= 1'b0;
            bus.finish     <= 1'b0;
            acc            <= '0;
            a_reg          <= '0;
            row            <= '0;
            col            <= '0;
            k              <= '0;
            dim_n          <= '0;
            dim_k          <= '0;
            dim_p          <= '0;
        end else begin
            bus.finish <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state     <= DIM;
                        bus.busy  <= 1'b1;
                        bus.read  <= 1'b1;
                        bus.write <= 1'b1;
                        bus.index <= 1'b0;
                        bus.i     <= '0;
                        bus.j     <= '0;
                    end
                end
                DIM: begin
                    // i doubles as the header word counter.
                    if (bus.i == AW'(0)) begin
                        dim_n <= rd_dim;
                        bus.i <= AW'(1);
                    end else if (bus.i == AW'(1)) begin
                        dim_k <= rd_dim;
                        bus.i <= AW'(2);
                    end else begin
                        dim_p <= rd_dim;
                        row   <= '0;
                        col   <= '0;
                        k     <= '0;
                        bus.i <= '0;
                        bus.j <= '0;
                        bus.write <= 1'b0;
                        if (dim_n == '0 || dim_k == '0 || rd_dim == '0) begin
                            state      <= DONE;
                            bus.read   <= 1'b0;
                            bus.finish <= 1'b1;
                        end else begin
                            state <= RDA;
                        end
                    end
                end
                RDA: begin
                    a_reg     <= $signed(bus.read_data);
                    state     <= RDB;
                    bus.index <= 1'b1;
                    bus.i     <= k;
                    bus.j     <= col;
                end
                RDB: begin
                    acc       <= acc_next;
                    bus.index <= 1'b0;
                    bus.i     <= row;
                    if (k == dim_k - 1'b1) begin
                        state          <= WR;
                        bus.read       <= 1'b0;
                        bus.write      <= 1'b1;
                        bus.j          <= col;
                        bus.write_data <= to_out(acc_next);
                    end else begin
                        state <= RDA;
                        k     <= k + 1'b1;
                        bus.j <= k + 1'b1;
                    end
                end
                WR: begin
                    acc            <= '0;
                    bus.write      <= 1'b0;
                    bus.write_data <= '0;
                    if (row == dim_n - 1'b1 && col == dim_p - 1'b1) begin
                        state      <= DONE;
                        bus.finish <= 1'b1;
                        bus.i      <= '0;
                        bus.j      <= '0;
                    end else begin
                        state    <= RDA;
                        bus.read <= 1'b1;
                        k        <= '0;
                        bus.j    <= '0;
                        if (col < dim_p - 1'b1) begin
                            col   <= col + 1'b1;
                            bus.i <= row;
                        end else begin
                            col   <= '0;
                            row   <= row + 1'b1;
                            bus.i <= row + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                    bus.i    <= '0;
                    bus.j    <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
